maxnet_loader: RTL and testbench

Front-end stage that feeds `Maxnet_model`. It takes IEEE-754 single-precision words one at a time over a valid/ready stream: eps first, then a1..a4. It holds all five as stable operands, issues a one-cycle `start` to the Maxnet core and waits for `finish`, with a timeout. It then returns the core's `out` over a valid/ready result port and flags any NaN operand.

---
 rtl/maxnet_loader.sv | 129 ++++++++++++
 tb/tb_maxnet_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_loader.sv
// Loader front-end for the Maxnet core: collects eps, a1..a4 over a stream,
// runs the core with a finish timeout and returns the result over a handshake.
module maxnet_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mx_start,
  output logic [31:0] mx_eps,
  output logic [31:0] mx_a1,
  output logic [31:0] mx_a2,
  output logic [31:0] mx_a3,
  output logic [31:0] mx_a4,
  input  logic        mx_finish,
  input  logic [31:0] mx_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        res_timeout,
  output logic        res_nan,
  output logic        busy
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [15:0] to_cnt;
  logic        seen_low;
  logic        accept, done, expire, word_nan;

  assign accept   = (state == LOAD) && in_valid;
  assign done     = mx_finish && seen_low;
  assign expire   = (to_cnt + 16'd1) == TMO;
  assign word_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && cnt == 3'd4) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (done || expire) state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge that enters the corresponding state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      mx_start  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == LOAD);
      mx_start  <= (state_nxt == START);
      res_valid <= (state_nxt == RESULT);
      busy      <= (state_nxt != LOAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 3'd0;
      mx_eps  <= 32'd0;
      mx_a1   <= 32'd0;
      mx_a2   <= 32'd0;
      mx_a3   <= 32'd0;
      mx_a4   <= 32'd0;
      res_nan <= 1'b0;
    end else if (accept) begin
      case (cnt)
        3'd0:    mx_eps <= in_data;
        3'd1:    mx_a1  <= in_data;
        3'd2:    mx_a2  <= in_data;
        3'd3:    mx_a3  <= in_data;
        3'd4:    mx_a4  <= in_data;
        default: ;
      endcase
      cnt     <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
      res_nan <= (cnt == 3'd0) ? word_nan : (res_nan | word_nan);
    end
  end

  // A finish only counts after a low sample, so a level left over from the
  // previous run cannot complete this one; completion beats timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= 16'd0;
      seen_low    <= 1'b0;
      res_data    <= 32'd0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        START: begin
          to_cnt   <= 16'd0;
          seen_low <= 1'b0;
        end
        WAIT: begin
          seen_low <= seen_low | ~mx_finish;
          if (done) begin
            res_data    <= mx_out;
            res_timeout <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (expire) begin
              res_data    <= 32'd0;
              res_timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_loader.sv
// Bench for maxnet_loader: a stub core plus a run-level reference model of
// the expected result, latency and NaN flag; two instances cover two timeouts.
module tb_maxnet_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, res_ready, mx_finish, sel;
  logic [31:0] in_data, mx_out;

  logic        in_ready_a, mx_start_a, res_valid_a, res_timeout_a, res_nan_a, busy_a;
  logic [31:0] eps_a, a1_a, a2_a, a3_a, a4_a, res_data_a;
  logic        in_ready_b, mx_start_b, res_valid_b, res_timeout_b, res_nan_b, busy_b;
  logic [31:0] eps_b, a1_b, a2_b, a3_b, a4_b, res_data_b;

  logic        in_ready_m, mx_start_m, res_valid_m, res_timeout_m, res_nan_m, busy_m;
  logic [31:0] res_data_m;
  logic [159:0] ops_m;

  maxnet_loader #(.TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_ready(in_ready_a), .mx_start(mx_start_a),
    .mx_eps(eps_a), .mx_a1(a1_a), .mx_a2(a2_a), .mx_a3(a3_a), .mx_a4(a4_a),
    .mx_finish(mx_finish), .mx_out(mx_out),
    .res_valid(res_valid_a), .res_data(res_data_a), .res_ready(res_ready & ~sel),
    .res_timeout(res_timeout_a), .res_nan(res_nan_a), .busy(busy_a)
  );

  maxnet_loader #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_data(in_data),
    .in_ready(in_ready_b), .mx_start(mx_start_b),
    .mx_eps(eps_b), .mx_a1(a1_b), .mx_a2(a2_b), .mx_a3(a3_b), .mx_a4(a4_b),
    .mx_finish(mx_finish), .mx_out(mx_out),
    .res_valid(res_valid_b), .res_data(res_data_b), .res_ready(res_ready & sel),
    .res_timeout(res_timeout_b), .res_nan(res_nan_b), .busy(busy_b)
  );

  assign in_ready_m    = sel ? in_ready_b    : in_ready_a;
  assign mx_start_m    = sel ? mx_start_b    : mx_start_a;
  assign res_valid_m   = sel ? res_valid_b   : res_valid_a;
  assign res_timeout_m = sel ? res_timeout_b : res_timeout_a;
  assign res_nan_m     = sel ? res_nan_b     : res_nan_a;
  assign busy_m        = sel ? busy_b        : busy_a;
  assign res_data_m    = sel ? res_data_b    : res_data_a;
  assign ops_m = sel ? {eps_b, a1_b, a2_b, a3_b, a4_b} : {eps_a, a1_a, a2_a, a3_a, a4_a};

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  logic [31:0] words [5];

  // Stub core: `since` counts negedges after the start pulse; finish drops
  // at low_at, rises at high_at (with out=stub_out), else holds its level.
  int since = -1;
  int low_at, high_at;
  bit never;
  logic [31:0] stub_out;
  always @(negedge clk) begin
    if (mx_start_m) since = 0;
    else if (since >= 0) since++;
    if (never) mx_finish = 1'b0;
    else if (since == low_at) mx_finish = 1'b0;
    else if (since == high_at) begin
      mx_finish = 1'b1;
      mx_out = stub_out;
    end
  end

  function automatic bit is_nan(logic [31:0] w);
    return (((w >> 23) & 32'hFF) == 32'hFF) && ((w & 32'h7FFFFF) != 32'd0);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (is_nan(w)) w[30] = 1'b0;
    return w;
  endfunction

  // Reference: number of WAIT cycles until the run ends, from the finish
  // level the core presents on each WAIT sample.
  function automatic int exp_wait(int tmo, bit prev, int lo, int hi, bit nev, output bit timed);
    bit low_seen, lvl;
    low_seen = 1'b0;
    for (int j = 1; j <= tmo; j++) begin
      lvl = nev ? 1'b0 : (j >= hi) ? 1'b1 : (j >= lo) ? 1'b0 : prev;
      if (lvl && low_seen) begin
        timed = 1'b0;
        return j;
      end
      if (!lvl) low_seen = 1'b1;
    end
    timed = 1'b1;
    return tmo;
  endfunction

  task automatic stream_words(input string name, input bit gapped);
    int t;
    for (int i = 0; i < 5; i++) begin
      if (gapped) begin
        in_valid = 1'b0;
        in_data = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = words[i];
      t = 0;
      while (!in_ready_m && t < 50) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 50) begin
        errors++;
        $display("[TB] FAIL %s accept word %0d: in_ready=0 required 1", name, i);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_once(input string name, input bit gapped, input int stall);
    bit prev, exp_to, exp_nan, got_rv, bad_ready, bad_stable;
    int exp_j, starts, start_c, rv_c, t, tmo;
    logic [31:0] exp_data, held;
    logic [159:0] exp_ops;
    prev = mx_finish;
    tmo = sel ? 16 : 255;
    exp_j = exp_wait(tmo, prev, low_at, high_at, never, exp_to);
    exp_data = exp_to ? 32'd0 : stub_out;
    exp_ops = {words[0], words[1], words[2], words[3], words[4]};
    exp_nan = 1'b0;
    for (int i = 0; i < 5; i++) exp_nan |= is_nan(words[i]);

    stream_words(name, gapped);

    starts = 0; start_c = -1; rv_c = 0; got_rv = 1'b0; bad_ready = 1'b0; t = 0;
    while (!got_rv && t < 400) begin
      if (mx_start_m) begin
        starts++;
        if (start_c < 0) start_c = cyc;
      end
      if (res_valid_m) begin
        got_rv = 1'b1;
        rv_c = cyc;
      end else begin
        if (in_ready_m) bad_ready = 1'b1;
        if (gapped) begin
          in_valid = ~in_valid;
          in_data = $urandom;
        end
        @(negedge clk);
        t++;
      end
    end

    checks++;
    if (!got_rv) begin
      errors++;
      in_valid = 1'b0;
      $display("[TB] FAIL %s res_valid: stayed 0 required 1 within 400 cycles", name);
      return;
    end
    checks++;
    if (starts !== 1) begin
      errors++;
      $display("[TB] FAIL %s start pulses: got %0d required 1", name, starts);
    end
    checks++;
    if (rv_c - start_c !== exp_j + 1) begin
      errors++;
      $display("[TB] FAIL %s latency start->res_valid: got %0d required %0d", name, rv_c - start_c, exp_j + 1);
    end
    checks++;
    if (res_data_m !== exp_data) begin
      errors++;
      $display("[TB] FAIL %s res_data: got %h required %h", name, res_data_m, exp_data);
    end
    checks++;
    if (res_timeout_m !== exp_to) begin
      errors++;
      $display("[TB] FAIL %s res_timeout: got %b required %b", name, res_timeout_m, exp_to);
    end
    checks++;
    if (res_nan_m !== exp_nan) begin
      errors++;
      $display("[TB] FAIL %s res_nan: got %b required %b", name, res_nan_m, exp_nan);
    end
    checks++;
    if (ops_m !== exp_ops) begin
      errors++;
      $display("[TB] FAIL %s operands: got %h required %h", name, ops_m, exp_ops);
    end
    checks++;
    if (busy_m !== 1'b1 || bad_ready) begin
      errors++;
      $display("[TB] FAIL %s busy/in_ready while running: busy=%b in_ready_seen=%b required 1/0", name, busy_m, bad_ready);
    end

    held = res_data_m;
    bad_stable = 1'b0;
    for (int k = 0; k < stall; k++) begin
      if (gapped) begin
        in_valid = ~in_valid;
        in_data = $urandom;
      end
      @(negedge clk);
      if (!res_valid_m || res_data_m !== held || in_ready_m || ops_m !== exp_ops) bad_stable = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad_stable) begin
      errors++;
      $display("[TB] FAIL %s stalled result: unstable=1 required 0 (res_data now %h, held %h)", name, res_data_m, held);
    end

    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if ({res_valid_m, in_ready_m, busy_m} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL %s handshake: valid/ready/busy=%b required 010", name, {res_valid_m, in_ready_m, busy_m});
    end
    checks++;
    if (ops_m !== exp_ops) begin
      errors++;
      $display("[TB] FAIL %s operands after handshake: got %h required %h", name, ops_m, exp_ops);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({in_ready_m, mx_start_m, res_valid_m, res_timeout_m, res_nan_m, busy_m} !== 6'b100000 ||
        res_data_m !== 32'd0 || ops_m !== 160'd0) begin
      errors++;
      $display("[TB] FAIL %s reset outputs: flags=%b data=%h ops=%h required 100000/0/0", name,
               {in_ready_m, mx_start_m, res_valid_m, res_timeout_m, res_nan_m, busy_m}, res_data_m, ops_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
  endtask

  task automatic test_nominal();
    words[0] = 32'hBE4CCCCD; words[1] = 32'h42FD6666; words[2] = 32'hC0A00000;
    words[3] = 32'h00000000; words[4] = 32'hBE4CCCCD;
    low_at = 1; high_at = 21; never = 1'b0; stub_out = 32'h42FD6666;
    run_once("nominal", 1'b0, 0);
  endtask

  task automatic test_gapped_stall();
    for (int i = 0; i < 5; i++) words[i] = rand_word();
    low_at = 1; high_at = $urandom_range(3, 20); stub_out = $urandom;
    run_once("gapped", 1'b1, 10);
  endtask

  task automatic test_stale();
    for (int i = 0; i < 5; i++) words[i] = rand_word();
    low_at = 2; high_at = 5; stub_out = 32'h40A00000;
    run_once("stale", 1'b0, 0);
  endtask

  task automatic test_nan();
    for (int i = 0; i < 5; i++) words[i] = rand_word();
    words[2] = 32'h7FC00000;
    low_at = 1; high_at = 4; stub_out = $urandom;
    run_once("nan_qnan", 1'b0, 0);
    for (int i = 0; i < 5; i++) words[i] = rand_word();
    words[2] = 32'h7F800000;
    stub_out = $urandom;
    run_once("nan_inf", 1'b0, 0);
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    never = 1'b1;
    for (int i = 0; i < 5; i++) words[i] = rand_word();
    run_once("timeout", 1'b0, 3);
    never = 1'b0;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit rose;
    int t;
    for (int i = 0; i < 5; i++) words[i] = rand_word();
    low_at = 1; high_at = 8; stub_out = $urandom;
    stream_words("rst_wait", 1'b0);
    t = 0;
    while (!mx_start_m && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!mx_start_m) begin
      errors++;
      $display("[TB] FAIL rst_wait start: mx_start=0 required 1");
    end
    repeat (2) @(negedge clk);
    rose = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (res_valid_m) rose = 1'b1;
    end
    rst = 1'b0;
    check_idle("rst_wait");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid_m || !in_ready_m) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("[TB] FAIL rst_wait no result: res_valid or !in_ready seen=1 required 0");
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) words[i] = $urandom;
      low_at = 1; high_at = $urandom_range(2, 12); stub_out = $urandom;
      run_once("back_to_back", 1'b0, 0);
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; res_ready = 1'b0;
    mx_finish = 1'b0; mx_out = 32'd0;
    low_at = 1; high_at = 21; never = 1'b0; stub_out = 32'd0;
    test_reset();
    test_nominal();
    test_gapped_stall();
    test_stale();
    test_nan();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
